// File: rtl/next_pc_btb_if.sv
// Fetch next-PC bundle: backend redirect/training and predictor inputs in,
// fetch PC and BTB prediction out.
interface next_pc_btb_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        btb_update_valid;
  logic [31:0] btb_update_pc;
  logic [31:0] btb_update_target;
  logic        prediction;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] next_pc;

  modport master (
    output stall, redirect_valid, redirect_pc,
    output btb_update_valid, btb_update_pc, btb_update_target, prediction,
    input  pc, pc_valid, pred_taken, pred_target, next_pc
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc,
    input  btb_update_valid, btb_update_pc, btb_update_target, prediction,
    output pc, pc_valid, pred_taken, pred_target, next_pc
  );
endinterface

// File: rtl/next_pc_btb.sv
// Fetch PC register with a direct-mapped BTB lookup; chooses the next fetch PC
// from BTB hit/target and the direction predictor, with backend redirect.
module next_pc_btb #(
  parameter int          BTB_IDX_W = 4,
  parameter logic [31:0] RESET_PC  = 32'h1eceb000
) (
  input logic          clk,
  input logic          rst,
  next_pc_btb_if.slave bus
);
  localparam int TAG_W   = 30 - BTB_IDX_W;
  localparam int ENTRIES = 1 << BTB_IDX_W;

  // state   | meaning
  // ST_RESET| pc not yet a real fetch address (pc_valid = 0)
  // ST_RUN  | fetching (pc_valid = 1)
  typedef enum logic {ST_RESET, ST_RUN} state_e;

  state_e              state_q;
  logic                pc_valid_q;
  logic [31:0]         pc_q, pc_d;
  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_W-1:0]    tag_q [ENTRIES];
  logic [29:0]         tgt_q [ENTRIES];

  logic [BTB_IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0]     lk_tag;
  logic                 hit;
  logic [31:0]          hit_target;
  logic [31:0]          next_pc;
  logic                 unused_low_bits;

  assign lk_idx     = pc_q[BTB_IDX_W+1:2];
  assign lk_tag     = pc_q[31:BTB_IDX_W+2];
  assign up_idx     = bus.btb_update_pc[BTB_IDX_W+1:2];
  assign hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign hit_target = {tgt_q[lk_idx], 2'b00};
  assign next_pc    = (hit && bus.prediction) ? hit_target : pc_q + 32'd4;

  assign unused_low_bits = ^{bus.redirect_pc[1:0], bus.btb_update_pc[1:0],
                             bus.btb_update_target[1:0]};

  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_valid)
      pc_d = {bus.redirect_pc[31:2], 2'b00};
    else if (!bus.stall)
      pc_d = next_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RESET;
      pc_valid_q <= 1'b0;
      pc_q       <= RESET_PC;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        ST_RESET: if (bus.redirect_valid || !bus.stall) begin
          state_q    <= ST_RUN;
          pc_valid_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_RUN;
          pc_valid_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      valid_q <= '0;
    else if (bus.btb_update_valid)
      valid_q[up_idx] <= 1'b1;
  end

  // Tag/target payload is meaningless until its valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (bus.btb_update_valid) begin
      tag_q[up_idx] <= bus.btb_update_pc[31:BTB_IDX_W+2];
      tgt_q[up_idx] <= bus.btb_update_target[31:2];
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_valid    = pc_valid_q;
  assign bus.pred_taken  = hit && bus.prediction;
  assign bus.pred_target = hit ? hit_target : 32'd0;
  assign bus.next_pc     = next_pc;
endmodule
